// File: rtl/rom_key_search.sv
// Writable key/payload table searched one entry per cycle, first match wins.
// A registered read stage sits between the table and the comparator.
module rom_key_search #(
  parameter int D     = 8,
  parameter int K     = 4,
  parameter int DEPTH = 16,
  parameter int IW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [K-1:0]  wr_key,
  input  logic [D-1:0]  wr_data,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [K-1:0]  req_key,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_hit,
  output logic [IW-1:0] rsp_index,
  output logic [D-2:0]  rsp_data
);

  typedef enum logic [1:0] {IDLE, SCAN, RESP} state_t;

  localparam logic [IW-1:0] LAST = IW'(DEPTH - 1);

  function automatic logic [IW-1:0] sat_inc(input logic [IW-1:0] p);
    return (p == LAST) ? p : p + IW'(1);
  endfunction

  logic [K-1:0]  key_mem_q  [DEPTH];
  logic [D-1:0]  data_mem_q [DEPTH];

  state_t        state_q, state_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [K-1:0]  key_q, key_d;

  logic          vld_p1_q, vld_p1_d;
  logic [IW-1:0] idx_p1_q, idx_p1_d;
  logic [K-1:0]  key_p1_q, key_p1_d;
  logic [D-1:0]  data_p1_q, data_p1_d;

  logic          rsp_valid_q, rsp_valid_d;
  logic          rsp_hit_q, rsp_hit_d;
  logic [IW-1:0] rsp_index_q, rsp_index_d;
  logic [D-2:0]  rsp_data_q, rsp_data_d;

  logic          hit_c, last_c;

  assign hit_c  = vld_p1_q && data_p1_q[0] && (key_p1_q == key_q);
  assign last_c = vld_p1_q && (idx_p1_q == LAST);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    key_d       = key_q;
    vld_p1_d    = 1'b0;
    idx_p1_d    = ptr_q;
    key_p1_d    = key_mem_q[ptr_q];
    data_p1_d   = data_mem_q[ptr_q];
    rsp_valid_d = rsp_valid_q;
    rsp_hit_d   = rsp_hit_q;
    rsp_index_d = rsp_index_q;
    rsp_data_d  = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          key_d   = req_key;
          ptr_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (hit_c) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b1;
          rsp_index_d = idx_p1_q;
          rsp_data_d  = data_p1_q[D-1:1];
          state_d     = RESP;
        end else if (last_c) begin
          rsp_valid_d = 1'b1;
          rsp_hit_d   = 1'b0;
          rsp_index_d = '0;
          rsp_data_d  = '0;
          state_d     = RESP;
        end else begin
          vld_p1_d = 1'b1;
          ptr_d    = sat_inc(ptr_q);
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control, table and response registers: reset clears everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      vld_p1_q    <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_hit_q   <= 1'b0;
      rsp_index_q <= '0;
      rsp_data_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        key_mem_q[i]  <= '0;
        data_mem_q[i] <= '0;
      end
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      vld_p1_q    <= vld_p1_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_hit_q   <= rsp_hit_d;
      rsp_index_q <= rsp_index_d;
      rsp_data_q  <= rsp_data_d;
      if (wr_en) begin
        key_mem_q[wr_addr]  <= wr_key;
        data_mem_q[wr_addr] <= wr_data;
      end
    end
  end

  // Read stage p1: snapshot of entry ptr, qualified by vld_p1_q.
  always_ff @(posedge clk) begin
    key_q     <= key_d;
    idx_p1_q  <= idx_p1_d;
    key_p1_q  <= key_p1_d;
    data_p1_q <= data_p1_d;
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_hit   = rsp_hit_q;
  assign rsp_index = rsp_index_q;
  assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_rom_key_search.sv
// Directed and randomized checks of rom_key_search against a first-match table model.
module tb_rom_key_search;
  localparam int D     = 8;
  localparam int K     = 4;
  localparam int DEPTH = 16;
  localparam int IW    = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [K-1:0]  wr_key = '0;
  logic [D-1:0]  wr_data = '0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [K-1:0]  req_key = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic          rsp_hit;
  logic [IW-1:0] rsp_index;
  logic [D-2:0]  rsp_data;

  rom_key_search #(.D(D), .K(K), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_key(wr_key), .wr_data(wr_data),
    .req_valid(req_valid), .req_ready(req_ready), .req_key(req_key),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_index(rsp_index), .rsp_data(rsp_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_err = 0;
  int t_acc = 0;

  logic [K-1:0] mkey  [DEPTH];
  logic [D-1:0] mdata [DEPTH];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) begin
      mkey[i]  = '0;
      mdata[i] = '0;
    end
  endtask

  // First valid entry with a matching key wins; latency from accept edge.
  task automatic model_search(input logic [K-1:0] key, output logic hit,
                              output int idx, output logic [D-2:0] data, output int lat);
    hit = 1'b0; idx = 0; data = '0; lat = 1 + DEPTH;
    for (int i = 0; i < DEPTH; i++) begin
      if (!hit && mdata[i][0] && mkey[i] == key) begin
        hit = 1'b1; idx = i; data = mdata[i][D-1:1]; lat = 2 + i;
      end
    end
  endtask

  task automatic write_entry(input int idx, input logic [K-1:0] key, input logic [D-1:0] data);
    wr_en = 1'b1; wr_addr = IW'(idx); wr_key = key; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    mkey[idx]  = key;
    mdata[idx] = data;
  endtask

  task automatic launch(input logic [K-1:0] key);
    chk("req_ready_before_req", req_ready, 1);
    req_valid = 1'b1; req_key = key;
    @(negedge clk);
    req_valid = 1'b0;
    t_acc = cyc;
  endtask

  task automatic wait_rsp(input string tag, input logic hit, input int idx,
                          input logic [D-2:0] data, input int lat);
    int k;
    k = 0;
    while (!rsp_valid && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_valid"}, rsp_valid, 1);
    chk({tag, "_latency"}, cyc - t_acc, lat);
    chk({tag, "_hit"}, rsp_hit, hit);
    chk({tag, "_index"}, rsp_index, idx);
    chk({tag, "_data"}, rsp_data, data);
    chk({tag, "_ready_busy"}, req_ready, 0);
  endtask

  task automatic ack_rsp(input string tag);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, "_valid_after_ack"}, rsp_valid, 0);
    chk({tag, "_ready_after_ack"}, req_ready, 1);
  endtask

  task automatic search_model(input string tag, input logic [K-1:0] key);
    logic hit; int idx; logic [D-2:0] data; int lat;
    model_search(key, hit, idx, data, lat);
    launch(key);
    wait_rsp(tag, hit, idx, data, lat);
    ack_rsp(tag);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_req_ready"}, req_ready, 1);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_hit"}, rsp_hit, 0);
    chk({tag, "_rsp_index"}, rsp_index, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [K-1:0] rk;
    model_clear();
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Empty table: full-length miss.
    launch(4'h3);
    wait_rsp("miss_empty", 1'b0, 0, 7'h00, 17);
    ack_rsp("miss_empty");

    write_entry(5, 4'hA, 8'hB5);
    launch(4'hA);
    wait_rsp("hit5", 1'b1, 5, 7'h5A, 7);
    ack_rsp("hit5");

    write_entry(5, 4'hA, 8'hB4);
    launch(4'hA);
    wait_rsp("invalid5", 1'b0, 0, 7'h00, 17);
    ack_rsp("invalid5");

    write_entry(2, 4'h7, 8'h11);
    write_entry(9, 4'h7, 8'h33);
    launch(4'h7);
    wait_rsp("dup", 1'b1, 2, 7'h08, 4);
    ack_rsp("dup");

    // Backpressure with stray requests that must be ignored.
    launch(4'h7);
    wait_rsp("bp", 1'b1, 2, 7'h08, 4);
    for (int c = 0; c < 10; c++) begin
      req_valid = (c == 2 || c == 5);
      req_key   = 4'h3;
      @(negedge clk);
      chk("bp_valid_hold", rsp_valid, 1);
      chk("bp_hit_hold", rsp_hit, 1);
      chk("bp_index_hold", rsp_index, 2);
      chk("bp_data_hold", rsp_data, 7'h08);
      chk("bp_ready_low", req_ready, 0);
    end
    req_valid = 1'b0;
    ack_rsp("bp");
    repeat (2) @(negedge clk);
    chk("bp_no_stray_valid", rsp_valid, 0);
    chk("bp_no_stray_busy", req_ready, 1);

    // Entry 12 written well before the scan reaches it.
    launch(4'hC);
    repeat (4) @(negedge clk);
    write_entry(12, 4'hC, 8'h2B);
    wait_rsp("wr_ahead", 1'b1, 12, 7'h15, 14);
    ack_rsp("wr_ahead");

    // Entry 0 written after it was already scanned.
    launch(4'hE);
    repeat (2) @(negedge clk);
    write_entry(0, 4'hE, 8'h81);
    wait_rsp("wr_behind", 1'b0, 0, 7'h00, 17);
    ack_rsp("wr_behind");
    search_model("wr_behind_after", 4'hE);

    // Randomized table updates and searches.
    for (int r = 0; r < 12; r++) begin
      for (int w = 0; w < 3; w++)
        write_entry($urandom_range(0, DEPTH - 1), K'($urandom), D'($urandom));
      if ($urandom_range(0, 1) == 1)
        rk = mkey[$urandom_range(0, DEPTH - 1)];
      else
        rk = K'($urandom);
      search_model($sformatf("rand%0d", r), rk);
    end

    // Reset while the pointer is at entry 6.
    write_entry(12, 4'hC, 8'h2B);
    launch(4'hC);
    repeat (6) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midscan_reset");
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    launch(4'hC);
    wait_rsp("post_reset", 1'b0, 0, 7'h00, 17);
    ack_rsp("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
